sum_byte_reader: RTL and testbench

- Consumer for the registered 32-bit sum words produced by the entropy-sum stage.
- Captures each sum word on a valid strobe into a small word FIFO.
- Emits the words one byte at a time over a valid/ready byte stream toward the output/readout logic.
- Detects and flags words lost to overflow, because the upstream stage has no backpressure.

---
 rtl/sum_byte_reader.sv | 195 +++++++++++++++++++
 tb/tb_sum_byte_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_byte_reader.sv
// sum_byte_reader
//   Takes the 32-bit sum words from the entropy-sum stage and stores them in a
//   small word FIFO. It then sends each word out one byte at a time on a
//   valid/ready byte stream. The sum stage cannot be stalled, so a word that
//   arrives when the FIFO has no room is dropped and the sticky overflow flag
//   is set.
//
// Parameters
//   DEPTH      word FIFO depth in words (power of two, >= 2)
//   MSB_FIRST  0: bits [7:0] go out first, 1: bits [31:24] go out first
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   sum_in      sum word from the sum stage
//   sum_vld     sum_in valid; one word per high cycle, no backpressure
//   byte_out    current output byte
//   byte_vld    byte_out valid
//   byte_rdy    downstream accepts byte_out when high together with byte_vld
//   fifo_level  words held in the FIFO, not counting the word being serialized
//   overflow    sticky: a word was dropped
//   ovf_clr     synchronous clear of overflow and drop_cnt
//   drop_cnt    dropped-word counter
//
// Configuration
//   SUM_READER_DROP_CNT_EN  when defined, drop_cnt counts dropped words and
//                           saturates at 0xFFFF. When undefined, drop_cnt is
//                           tied to zero and no counter flops are built.
//
// FSM states
//   state  | meaning
//   S_IDLE | no word held, byte_vld low; pops the FIFO head when it is non-empty
//   S_EMIT | word held, byte_vld high; presents byte idx_q of the held word

module sum_byte_reader #(
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                sum_in,
  input  logic                       sum_vld,
  output logic [7:0]                 byte_out,
  output logic                       byte_vld,
  input  logic                       byte_rdy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t          state_q;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [31:0]     word_q;
  logic [1:0]      idx_q;

  logic            fifo_empty;
  logic            fifo_full;
  logic            last_xfer;
  logic            pop;
  logic            push;
  logic            drop;
  logic [31:0]     head_word;

  // Returns byte number i (in transmit order) of word w.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    logic [1:0] k;
    logic [7:0] b;
    k = (MSB_FIRST != 0) ? ~i : i;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(DEPTH));
  assign head_word  = mem[rd_ptr_q];

  // Final byte of the held word is being accepted this cycle.
  assign last_xfer  = (state_q == S_EMIT) && byte_rdy && (idx_q == 2'd3);

  // Pop either starts a word from idle or chains the next word straight after
  // the final byte, so consecutive words go out with no gap.
  assign pop  = !fifo_empty && ((state_q == S_IDLE) || last_xfer);

  // When the FIFO is full, a pop on the same edge frees the slot the push
  // needs. An empty FIFO never pops on the push edge, so there is no bypass.
  assign push = sum_vld && (!fifo_full || pop);
  assign drop = sum_vld && !push;

  assign fifo_level = level_q;

  // FIFO storage is not reset. The pointers and the level define which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= sum_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  // Serializer FSM. byte_out and byte_vld are registered. They change only on
  // a pop or on an accepted byte, so they hold steady while the downstream
  // stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      idx_q    <= '0;
      byte_out <= 8'h00;
      byte_vld <= 1'b0;
    end else begin
      if (pop) begin
        state_q  <= S_EMIT;
        word_q   <= head_word;
        idx_q    <= 2'd0;
        byte_out <= byte_sel(head_word, 2'd0);
        byte_vld <= 1'b1;
      end else if (state_q == S_EMIT && byte_rdy) begin
        if (idx_q == 2'd3) begin
          state_q  <= S_IDLE;
          byte_vld <= 1'b0;
        end else begin
          idx_q    <= idx_q + 2'd1;
          byte_out <= byte_sel(word_q, idx_q + 2'd1);
        end
      end
    end
  end

  // If a drop and a clear happen on the same edge, the drop wins, so the new
  // loss is still reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef SUM_READER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (ovf_clr) begin
        drop_cnt_q <= 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end else if (ovf_clr) begin
      drop_cnt_q <= '0;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sum_byte_reader.sv
module tb_sum_byte_reader;

  localparam int DEPTH     = 2;
  localparam int MSB_FIRST = 0;

`ifdef SUM_READER_DROP_CNT_EN
  localparam logic [15:0] DROP1 = 16'd1;
`else
  localparam logic [15:0] DROP1 = 16'd0;
`endif

  logic                   clk;
  logic                   rst_n;
  logic [31:0]            sum_in;
  logic                   sum_vld;
  logic [7:0]             byte_out;
  logic                   byte_vld;
  logic                   byte_rdy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;
  logic                   ovf_clr;
  logic [15:0]            drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  sum_byte_reader #(.DEPTH(DEPTH), .MSB_FIRST(MSB_FIRST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sum_in     (sum_in),
    .sum_vld    (sum_vld),
    .byte_out   (byte_out),
    .byte_vld   (byte_vld),
    .byte_rdy   (byte_rdy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queues the four expected bytes of word w in transmit order.
  task automatic expect_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      if (MSB_FIRST != 0) exp_q.push_back(t[31-8*i -: 8]);
      else                exp_q.push_back(t[8*i +: 8]);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares accepted bytes against the scoreboard and checks that
  // the output holds steady while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend) begin
        check("hold_vld", {31'd0, byte_vld}, 32'd1);
        check("hold_byte", {24'd0, byte_out}, {24'd0, hold_byte});
      end
      if (byte_vld && byte_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
        end else begin
          check("byte_out", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
        end
      end
      hold_pend = byte_vld && !byte_rdy;
      hold_byte = byte_out;
    end else begin
      hold_pend = 1'b0;
    end
  end

  int max_lvl;

  initial begin
    rst_n    = 1'b0;
    sum_in   = '0;
    sum_vld  = 1'b0;
    byte_rdy = 1'b0;
    ovf_clr  = 1'b0;
    tick(2);
    check("rst_byte_vld", {31'd0, byte_vld}, 32'd0);
    check("rst_byte_out", {24'd0, byte_out}, 32'h00);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // 1: single word, byte_rdy high
    byte_rdy = 1'b1;
    sum_in = 32'h89AB_CDEF; sum_vld = 1'b1; expect_word(sum_in);
    tick(1);
    sum_vld = 1'b0;
    check("t1_vld_at_push", {31'd0, byte_vld}, 32'd0);
    check("t1_level_after_push", 32'(fifo_level), 32'd1);
    tick(1);
    check("t1_first_vld", {31'd0, byte_vld}, 32'd1);
    check("t1_first_byte", {24'd0, byte_out}, 32'hEF);
    check("t1_level_after_pop", 32'(fifo_level), 32'd0);
    tick(4);
    check("t1_idle_vld", {31'd0, byte_vld}, 32'd0);
    check("t1_idle_level", 32'(fifo_level), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // 2: backpressure for 3 cycles after byte_vld rises
    byte_rdy = 1'b0;
    sum_in = 32'h89AB_CDEF; sum_vld = 1'b1; expect_word(sum_in);
    tick(1);
    sum_vld = 1'b0;
    tick(1);
    tick(3);
    check("t2_held_vld", {31'd0, byte_vld}, 32'd1);
    check("t2_held_byte", {24'd0, byte_out}, 32'hEF);
    byte_rdy = 1'b1;
    tick(4);
    check("t2_idle_vld", {31'd0, byte_vld}, 32'd0);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: back-to-back words, no idle cycle between them
    sum_in = 32'h1122_3344; sum_vld = 1'b1; expect_word(sum_in);
    tick(1);
    max_lvl = int'(fifo_level);
    sum_in = 32'h5566_7788; expect_word(sum_in);
    tick(1);
    sum_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      check("t3_stream_vld", {31'd0, byte_vld}, 32'd1);
      tick(1);
    end
    check("t3_peak_level", 32'(max_lvl), 32'd1);
    check("t3_idle_vld", {31'd0, byte_vld}, 32'd0);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: overflow with byte_rdy low
    byte_rdy = 1'b0;
    sum_vld = 1'b1;
    sum_in = 32'hA3A2_A1A0; expect_word(sum_in); tick(1);
    sum_in = 32'hB3B2_B1B0; expect_word(sum_in); tick(1);
    sum_in = 32'hC3C2_C1C0; expect_word(sum_in); tick(1);
    check("t4_no_ovf_yet", {31'd0, overflow}, 32'd0);
    sum_in = 32'hD3D2_D1D0; tick(1);
    sum_vld = 1'b0;
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    check("t4_drop_cnt", {16'd0, drop_cnt}, {16'd0, DROP1});
    check("t4_level_full", 32'(fifo_level), 32'd2);
    check("t4_held_byte", {24'd0, byte_out}, 32'hA0);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    check("t4_clr_overflow", {31'd0, overflow}, 32'd0);
    check("t4_clr_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    // drop on the same edge as the clear: drop wins
    ovf_clr = 1'b1; sum_vld = 1'b1; sum_in = 32'hEEEE_EEEE; tick(1);
    ovf_clr = 1'b0; sum_vld = 1'b0;
    check("t4_drop_wins_ovf", {31'd0, overflow}, 32'd1);
    check("t4_drop_wins_cnt", {16'd0, drop_cnt}, {16'd0, DROP1});
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    check("t4_clr2_overflow", {31'd0, overflow}, 32'd0);

    // 5: full FIFO, push on the same edge as the final-byte transfer
    byte_rdy = 1'b1;
    tick(3);
    sum_vld = 1'b1; sum_in = 32'hF3F2_F1F0; expect_word(sum_in);
    tick(1);
    sum_vld = 1'b0;
    check("t5_level_kept", 32'(fifo_level), 32'd2);
    check("t5_no_overflow", {31'd0, overflow}, 32'd0);
    check("t5_next_word", {24'd0, byte_out}, 32'hB0);
    tick(13);
    check("t5_idle_vld", {31'd0, byte_vld}, 32'd0);
    check("t5_idle_level", 32'(fifo_level), 32'd0);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset in the middle of a word
    sum_in = 32'h89AB_CDEF; sum_vld = 1'b1; expect_word(sum_in);
    sum_in = 32'h89AB_CDEF;
    tick(1);
    sum_vld = 1'b0;
    tick(4);
    check("t6_before_rst", {24'd0, byte_out}, 32'h89);
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld", {31'd0, byte_vld}, 32'd0);
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    sum_in = 32'hDEAD_BEEF; sum_vld = 1'b1; expect_word(sum_in);
    tick(1);
    sum_vld = 1'b0;
    tick(1);
    check("t6_first_byte", {24'd0, byte_out}, 32'hEF);
    tick(4);
    check("t6_idle_vld", {31'd0, byte_vld}, 32'd0);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
